// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the decoded control word that travels through the
// ID -> EX -> MEM -> WB control pipeline (ctrl_pipe_chain).
//  - bit positions of every field in the 13-bit control word
//  - default per-stage keep masks (EX keeps all, MEM keeps memory fields,
//    WB keeps only RF_EN)
//  - saturating 16-bit increment used by the optional performance counters
// ---------------------------------------------------------------------------
package ctrl_pkg;

  localparam int CTRL_W = 13;

  // Field positions inside the control word
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 3;
  localparam int AM_BIT    = 4;
  localparam int S_EN_BIT  = 5;
  localparam int LOAD_BIT  = 6;
  localparam int RF_EN_BIT = 7;
  localparam int SIZE_BIT  = 8;
  localparam int RW_BIT    = 9;
  localparam int EN_BIT    = 10;
  localparam int BL_BIT    = 11;
  localparam int B_BIT     = 12;

  // Fields each stage still needs once the word has entered it
  localparam logic [CTRL_W-1:0] EX_MASK  = 13'h1FFF;
  localparam logic [CTRL_W-1:0] MEM_MASK = 13'h07C0;
  localparam logic [CTRL_W-1:0] WB_MASK  = 13'h0080;

  // Increment when en is set, sticking at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
    logic [15:0] res;
    if (en && (val != 16'hFFFF)) begin
      res = val + 16'h0001;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_chain_if
// Bundle between the decode stage and the control pipeline.
//  master (decode side) drives: LE, S, flush, in_valid, in_ctrl
//  slave  (pipeline)    drives: stage_ctrl, stage_vld, occupancy,
//                                stall_cnt, bubble_cnt
// ---------------------------------------------------------------------------
interface ctrl_pipe_chain_if #(
  parameter int CTRL_W = 13,
  parameter int STAGES = 3
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic                       LE;
  logic                       S;
  logic                       flush;
  logic                       in_valid;
  logic [CTRL_W-1:0]          in_ctrl;
  logic [STAGES*CTRL_W-1:0]   stage_ctrl;
  logic [STAGES-1:0]          stage_vld;
  logic [OCC_W-1:0]           occupancy;
  logic [15:0]                stall_cnt;
  logic [15:0]                bubble_cnt;

  modport master (
    output LE, S, flush, in_valid, in_ctrl,
    input  stage_ctrl, stage_vld, occupancy, stall_cnt, bubble_cnt
  );

  modport slave (
    input  LE, S, flush, in_valid, in_ctrl,
    output stage_ctrl, stage_vld, occupancy, stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/ctrl_stage_reg.sv
// ---------------------------------------------------------------------------
// ctrl_stage_reg
// One stage of the control pipeline: control word + valid flop.
//  clk, rst     clock / asynchronous active-high reset
//  load_i       advance: capture ctrl_i/vld_i
//  clear_i      load a bubble (wins over load_i)
//  ctrl_i       incoming control word (pruned with KEEP on entry)
//  vld_i        incoming valid
//  ctrl_o       registered control word (always 0 when vld_o=0)
//  vld_o        registered valid
//  nxt_vld_o    valid value that will be captured on the next edge
// ---------------------------------------------------------------------------
module ctrl_stage_reg #(
  parameter int              W    = 13,
  parameter logic [W-1:0]    KEEP = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [W-1:0]  ctrl_i,
  input  logic          vld_i,
  output logic [W-1:0]  ctrl_o,
  output logic          vld_o,
  output logic          nxt_vld_o
);

  logic [W-1:0] ctrl_q, ctrl_d;
  logic         vld_q, vld_d;

  // Next-state selection: bubble, advance (pruned), or hold
  always_comb begin
    ctrl_d = ctrl_q;
    vld_d  = vld_q;
    if (clear_i) begin
      ctrl_d = '0;
      vld_d  = 1'b0;
    end else if (load_i) begin
      vld_d = vld_i;
      // Gating by vld_i keeps an invalid slot all-zero
      ctrl_d = vld_i ? (ctrl_i & KEEP) : '0;
    end else begin
      ctrl_d = ctrl_q;
      vld_d  = vld_q;
    end
  end

  // Stage flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      vld_q  <= vld_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign vld_o     = vld_q;
  assign nxt_vld_o = vld_d;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_chain
// Control-signal pipeline carrying decoded control bits from ID through
// EX / MEM / WB, with per-stage valid, stall hold, flush of stage 0,
// per-stage field pruning and occupancy tracking.
//  clk          clock, rising edge
//  R            asynchronous active-high reset
//  bus (slave)  LE, S, flush, in_valid, in_ctrl in;
//               stage_ctrl, stage_vld, occupancy, stall_cnt, bubble_cnt out
// Build option: define CTRL_PIPE_PERF_EN to get the saturating stall and
// bubble counters; otherwise both outputs are constant 16'h0000.
// ---------------------------------------------------------------------------
module ctrl_pipe_chain
  import ctrl_pkg::*;
#(
  parameter int                          CTRL_W    = ctrl_pkg::CTRL_W,
  parameter int                          STAGES    = 3,
  parameter logic [STAGES*CTRL_W-1:0]    KEEP_MASK = {WB_MASK, MEM_MASK, EX_MASK}
) (
  input  logic                 clk,
  input  logic                 R,
  ctrl_pipe_chain_if.slave     bus
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [CTRL_W-1:0] ctrl_s [STAGES];
  logic [STAGES-1:0] vld_s;
  logic [STAGES-1:0] nxt_vld_s;
  logic              bubble_in_s;
  logic [OCC_W-1:0]  occ_q, occ_d;

  // Stage 0 takes a bubble on flush (even while stalled) or when advancing
  // without a real instruction
  assign bubble_in_s = bus.flush | (bus.LE & (bus.S | ~bus.in_valid));

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        ctrl_stage_reg #(
          .W    (CTRL_W),
          .KEEP (KEEP_MASK[0 +: CTRL_W])
        ) u_stage (
          .clk       (clk),
          .rst       (R),
          .load_i    (bus.LE),
          .clear_i   (bubble_in_s),
          .ctrl_i    (bus.in_ctrl),
          .vld_i     (1'b1),
          .ctrl_o    (ctrl_s[0]),
          .vld_o     (vld_s[0]),
          .nxt_vld_o (nxt_vld_s[0])
        );
      end else begin : g_rest
        ctrl_stage_reg #(
          .W    (CTRL_W),
          .KEEP (KEEP_MASK[k*CTRL_W +: CTRL_W])
        ) u_stage (
          .clk       (clk),
          .rst       (R),
          .load_i    (bus.LE),
          .clear_i   (1'b0),
          .ctrl_i    (ctrl_s[k-1]),
          .vld_i     (vld_s[k-1]),
          .ctrl_o    (ctrl_s[k]),
          .vld_o     (vld_s[k]),
          .nxt_vld_o (nxt_vld_s[k])
        );
      end
      assign bus.stage_ctrl[k*CTRL_W +: CTRL_W] = ctrl_s[k];
    end
  endgenerate

  assign bus.stage_vld = vld_s;

  // Population count of the valid vector the stages are about to load
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(nxt_vld_s[i]);
    end
  end

  // Occupancy register, updated on the same edge as the stage valids
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.occupancy = occ_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] bubble_q, bubble_d;

  // Saturating next values for the performance counters
  always_comb begin
    stall_d  = sat_inc16(stall_q, ~bus.LE);
    bubble_d = sat_inc16(bubble_q, bubble_in_s);
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      stall_q  <= 16'h0000;
      bubble_q <= 16'h0000;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.stall_cnt  = stall_q;
  assign bus.bubble_cnt = bubble_q;
`else
  assign bus.stall_cnt  = 16'h0000;
  assign bus.bubble_cnt = 16'h0000;
`endif

endmodule
